// File: rtl/fsm_stim_driver.sv
// rtl/fsm_stim_driver.sv - scripted stimulus/response self-test driver for the gate/access FSM
module fsm_stim_driver #(
  parameter int DEPTH = 8,
  parameter int HOLD  = 4,
  parameter int CNT_W = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [$clog2(DEPTH):0]   len,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [13:0]              wr_data,
  input  logic [5:0]               resp_in,
  output logic [7:0]               stim_out,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [CNT_W-1:0]         err_count,
  output logic [$clog2(DEPTH)-1:0] first_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [LW-1:0]    DEPTH_L = LW'(DEPTH);
  localparam logic [HW-1:0]    HOLD_M1 = HW'(HOLD - 1);
  localparam logic [CNT_W-1:0] ERR_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_CHECK
  } state_t;

  state_t           state_q;
  logic [13:0]      mem_q [DEPTH];
  logic [AW-1:0]    idx_q;
  logic [LW-1:0]    len_q;
  logic [HW-1:0]    cnt_q;
  logic [7:0]       stim_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [CNT_W-1:0] err_q;
  logic [AW-1:0]    first_q;

  logic [LW-1:0]    len_d;
  logic [13:0]      entry;
  logic             mismatch;
  logic             last_step;
  logic [CNT_W-1:0] err_d;

  // Clamp the requested length, fetch the current entry and work out the saturating error count.
  always_comb begin
    len_d     = (len > DEPTH_L) ? DEPTH_L : len;
    entry     = mem_q[idx_q];
    mismatch  = (resp_in != entry[13:8]);
    last_step = ({1'b0, idx_q} == (len_q - LW'(1)));
    err_d     = err_q;
    if (mismatch && (err_q != ERR_MAX)) begin
      err_d = err_q + CNT_W'(1);
    end
  end

  // Script storage: cleared on reset, writable only while the sequencer is idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en && (state_q == S_IDLE)) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Step sequencer: drive, settle for HOLD cycles, then compare and advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      stim_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      first_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            err_q   <= '0;
            first_q <= '0;
            if (len_d == '0) begin
              // Empty run completes on the spot and trivially passes.
              done_q <= 1'b1;
              pass_q <= 1'b1;
            end else begin
              idx_q   <= '0;
              len_q   <= len_d;
              done_q  <= 1'b0;
              pass_q  <= 1'b0;
              busy_q  <= 1'b1;
              state_q <= S_DRIVE;
            end
          end
        end
        S_DRIVE: begin
          stim_q  <= entry[7:0];
          cnt_q   <= HOLD_M1;
          state_q <= S_SETTLE;
        end
        S_SETTLE: begin
          if (cnt_q == '0) begin
            state_q <= S_CHECK;
          end else begin
            cnt_q <= cnt_q - HW'(1);
          end
        end
        S_CHECK: begin
          err_q <= err_d;
          // A zero count before this step means no earlier mismatch in this run.
          if (mismatch && (err_q == '0)) begin
            first_q <= idx_q;
          end
          if (last_step) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            stim_q  <= '0;
            pass_q  <= (err_d == '0);
            state_q <= S_IDLE;
          end else begin
            idx_q   <= idx_q + AW'(1);
            state_q <= S_DRIVE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign stim_out  = stim_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign first_err = first_q;

endmodule

// File: tb/tb_fsm_stim_driver.sv
// tb/tb_fsm_stim_driver.sv - scoreboard testbench for fsm_stim_driver
module tb_fsm_stim_driver;

  localparam int DEPTH   = 8;
  localparam int HOLD    = 4;
  localparam int CNT_W   = 2;
  localparam int AW      = 3;
  localparam int LW      = 4;
  localparam int STEP    = HOLD + 2;
  localparam int ERR_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [LW-1:0]    len;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [13:0]      wr_data;
  logic [5:0]       resp_in;
  logic [7:0]       stim_out;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] err_count;
  logic [AW-1:0]    first_err;

  fsm_stim_driver #(.DEPTH(DEPTH), .HOLD(HOLD), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .len       (len),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .resp_in   (resp_in),
    .stim_out  (stim_out),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .first_err (first_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [13:0] model_mem [DEPTH];
  logic [5:0]  resp_plan [DEPTH];
  logic [7:0]  stim_q [$];

  typedef struct {
    int               cycles;
    logic             pass;
    logic [CNT_W-1:0] err;
    logic [AW-1:0]    first;
  } res_t;
  res_t res_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Responder: plays the FSM, presenting the planned response for the current step while busy.
  int rcyc = 0;
  always @(negedge clk) begin
    if (reset || !busy) begin
      rcyc    = 0;
      resp_in = 6'h00;
    end else begin
      resp_in = resp_plan[((rcyc / STEP) < DEPTH) ? (rcyc / STEP) : (DEPTH - 1)];
      rcyc++;
    end
  end

  // Monitor: checks stim_out at every compare cycle and the run results when busy drops.
  int   mcyc = 0;
  logic busy_prev = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      mcyc      = 0;
      busy_prev = 1'b0;
    end else begin
      if (busy) begin
        if ((mcyc % STEP) == (STEP - 1)) begin
          if (stim_q.size() == 0) check("stim_q_size", 0, 1);
          else check("stim_out", {24'h0, stim_out}, {24'h0, stim_q.pop_front()});
        end
        mcyc++;
      end else if (busy_prev) begin
        if (res_q.size() == 0) begin
          check("res_q_size", 0, 1);
        end else begin
          res_t r;
          r = res_q.pop_front();
          check("busy_cycles", mcyc, r.cycles);
          check("done", {31'h0, done}, 1);
          check("pass", {31'h0, pass}, {31'h0, r.pass});
          check("err_count", {30'h0, err_count}, {30'h0, r.err});
          check("first_err", {29'h0, first_err}, {29'h0, r.first});
          check("stim_out_end", {24'h0, stim_out}, 0);
        end
        mcyc = 0;
      end
      busy_prev = busy;
    end
  end

  task automatic wr(input int a, input logic [13:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = d;
    model_mem[a] = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Reference model: compute the expected run from the script and the planned responses.
  task automatic launch(input int l, input bit with_wr, input int a, input logic [13:0] d);
    int lc;
    int e;
    int f;
    bit any;
    @(negedge clk);
    if (with_wr) begin
      wr_en   = 1'b1;
      wr_addr = AW'(a);
      wr_data = d;
      model_mem[a] = d;
    end
    lc  = (l > DEPTH) ? DEPTH : l;
    e   = 0;
    f   = 0;
    any = 1'b0;
    for (int s = 0; s < lc; s++) begin
      stim_q.push_back(model_mem[s][7:0]);
      if (resp_plan[s] !== model_mem[s][13:8]) begin
        if (!any) f = s;
        any = 1'b1;
        if (e < ERR_MAX) e++;
      end
    end
    res_q.push_back('{lc * STEP, (e == 0), CNT_W'(e), AW'(f)});
    start = 1'b1;
    len   = LW'(l);
    @(negedge clk);
    start = 1'b0;
    wr_en = 1'b0;
  endtask

  task automatic wait_run();
    int t;
    t = 0;
    while ((res_q.size() != 0) && (t < DEPTH * STEP + 20)) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("run_complete", res_q.size(), 0);
    res_q.delete();
    stim_q.delete();
  endtask

  task automatic plan_expected();
    for (int s = 0; s < DEPTH; s++) resp_plan[s] = model_mem[s][13:8];
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    len     = '0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      model_mem[i] = '0;
      resp_plan[i] = '0;
    end

    // Reset then idle
    repeat (2) @(negedge clk);
    check("reset_outputs", {15'h0, stim_out, busy, done, pass, err_count, first_err}, 0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_outputs", {15'h0, stim_out, busy, done, pass, err_count, first_err}, 0);
    end
    launch(1, 1'b0, 0, '0);
    wait_run();

    // Full-pass run
    wr(0, {6'h01, 8'h01});
    wr(1, {6'h08, 8'h44});
    wr(2, {6'h20, 8'hC0});
    plan_expected();
    launch(3, 1'b0, 0, '0);
    wait_run();

    // Mismatch at step 1
    resp_plan[1] = 6'h3F;
    launch(3, 1'b0, 0, '0);
    wait_run();

    // len=0 start: immediate pass with the count cleared, busy never raised
    @(negedge clk);
    start = 1'b1;
    len   = '0;
    @(negedge clk);
    start = 1'b0;
    check("len0_done", {31'h0, done}, 1);
    check("len0_pass", {31'h0, pass}, 1);
    check("len0_err", {30'h0, err_count}, 0);
    check("len0_busy", {31'h0, busy}, 0);
    @(negedge clk);
    check("len0_busy_later", {31'h0, busy}, 0);

    // Saturation and clamp: every step mismatches, len above DEPTH
    for (int s = 0; s < DEPTH; s++) wr(s, {6'($urandom), 8'($urandom)});
    for (int s = 0; s < DEPTH; s++) resp_plan[s] = ~model_mem[s][13:8];
    launch(12, 1'b0, 0, '0);
    wait_run();

    // Ignored controls mid-run, then a second run proves the script is intact
    wr(0, {6'h01, 8'h01});
    wr(1, {6'h08, 8'h44});
    wr(2, {6'h20, 8'hC0});
    plan_expected();
    launch(3, 1'b0, 0, '0);
    repeat (3) @(negedge clk);
    start   = 1'b1;
    len     = LW'(1);
    wr_en   = 1'b1;
    wr_addr = '0;
    wr_data = 14'h3FFF;
    @(negedge clk);
    start = 1'b0;
    wr_en = 1'b0;
    wait_run();
    launch(3, 1'b0, 0, '0);
    wait_run();

    // Write and start on the same edge: the step uses the new data
    plan_expected();
    resp_plan[0] = 6'h15;
    launch(1, 1'b1, 0, {6'h15, 8'h9A});
    wait_run();

    // Randomized runs
    for (int it = 0; it < 8; it++) begin
      int nw;
      int l;
      nw = $urandom_range(1, 3);
      for (int k = 0; k < nw; k++) wr($urandom_range(0, DEPTH - 1), 14'($urandom));
      for (int s = 0; s < DEPTH; s++)
        resp_plan[s] = ($urandom_range(0, 3) == 0) ? 6'($urandom) : model_mem[s][13:8];
      l = $urandom_range(1, 10);
      launch(l, 1'b0, 0, '0);
      wait_run();
    end

    // Reset mid-run during SETTLE of step 2
    plan_expected();
    launch(3, 1'b0, 0, '0);
    repeat (2 * STEP + 1) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_busy", {31'h0, busy}, 0);
    check("rst_stim", {24'h0, stim_out}, 0);
    check("rst_done", {31'h0, done}, 0);
    res_q.delete();
    stim_q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      model_mem[i] = '0;
      resp_plan[i] = '0;
    end
    @(negedge clk);
    reset = 1'b0;
    launch(1, 1'b0, 0, '0);
    wait_run();

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
